// File: rtl/fir_coeff_ctrl.sv
// Double-banked 5x5 FIR kernel store: cfg writes go to a shadow bank.
// A commit copies the whole shadow bank into the active bank, either at the next frame start or at once.
module fir_coeff_ctrl #(
    parameter int COEFF_W    = 16,
    parameter int NTAPS      = 25,
    parameter bit SYNC_TO_VS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [4:0]                cfg_addr,
    input  logic signed [COEFF_W-1:0] cfg_wdata,
    output logic signed [COEFF_W-1:0] cfg_rdata,
    input  logic                      cfg_commit,
    output logic                      cfg_busy,
    output logic                      cfg_err,
    input  logic                      cfg_err_clr,
    input  logic                      vs_i,
    output logic                      swap_done,
    output logic signed [COEFF_W-1:0] coeff00, coeff01, coeff02, coeff03, coeff04,
    output logic signed [COEFF_W-1:0] coeff10, coeff11, coeff12, coeff13, coeff14,
    output logic signed [COEFF_W-1:0] coeff20, coeff21, coeff22, coeff23, coeff24,
    output logic signed [COEFF_W-1:0] coeff30, coeff31, coeff32, coeff33, coeff34,
    output logic signed [COEFF_W-1:0] coeff40, coeff41, coeff42, coeff43, coeff44
);

    typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

    localparam logic [4:0]                LAST_ADDR  = 5'(NTAPS - 1);
    localparam int                        CENTER     = NTAPS / 2;
    localparam logic signed [COEFF_W-1:0] UNITY_COEF = COEFF_W'(256);

    state_t                      state_q, state_d;
    logic                        vs_d_q;
    logic                        err_q, err_d;
    logic signed [COEFF_W-1:0]   rdata_q;
    logic signed [COEFF_W-1:0]   shadow_q [NTAPS];
    logic signed [COEFF_W-1:0]   active_q [NTAPS];
    logic                        vs_rise, addr_ok, wr_ok, wr_bad, load_active;

    assign vs_rise     = vs_i & ~vs_d_q;
    assign addr_ok     = (cfg_addr <= LAST_ADDR);
    assign cfg_busy    = (state_q != IDLE);
    assign wr_ok       = cfg_we & addr_ok & ~cfg_busy;
    assign wr_bad      = cfg_we & (~addr_ok | cfg_busy);
    assign load_active = (state_q == PENDING) && (state_d == SWAP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_commit) state_d = PENDING;
            PENDING: if (!SYNC_TO_VS || vs_rise) state_d = SWAP;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as a clear must survive.
    always_comb begin
        err_d = err_q;
        if (cfg_err_clr) err_d = 1'b0;
        if (wr_bad)      err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vs_d_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            vs_d_q  <= vs_i;
            err_q   <= err_d;
            rdata_q <= addr_ok ? shadow_q[cfg_addr] : '0;
        end
    end

    // Both banks come out of reset holding the identity kernel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= (i == CENTER) ? UNITY_COEF : '0;
                active_q[i] <= (i == CENTER) ? UNITY_COEF : '0;
            end
        end else begin
            if (wr_ok) shadow_q[cfg_addr] <= cfg_wdata;
            if (load_active) begin
                for (int i = 0; i < NTAPS; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

    assign cfg_rdata = rdata_q;
    assign cfg_err   = err_q;
    assign swap_done = (state_q == SWAP);

    assign coeff00 = active_q[0];  assign coeff01 = active_q[1];  assign coeff02 = active_q[2];
    assign coeff03 = active_q[3];  assign coeff04 = active_q[4];
    assign coeff10 = active_q[5];  assign coeff11 = active_q[6];  assign coeff12 = active_q[7];
    assign coeff13 = active_q[8];  assign coeff14 = active_q[9];
    assign coeff20 = active_q[10]; assign coeff21 = active_q[11]; assign coeff22 = active_q[12];
    assign coeff23 = active_q[13]; assign coeff24 = active_q[14];
    assign coeff30 = active_q[15]; assign coeff31 = active_q[16]; assign coeff32 = active_q[17];
    assign coeff33 = active_q[18]; assign coeff34 = active_q[19];
    assign coeff40 = active_q[20]; assign coeff41 = active_q[21]; assign coeff42 = active_q[22];
    assign coeff43 = active_q[23]; assign coeff44 = active_q[24];

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a frame-synced instance plus an immediate-swap instance.
module tb_fir_coeff_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_err_clr = 1'b0;
    logic        vs_i = 1'b0;

    logic [15:0] rdata1, rdata0;
    logic        busy1, busy0, err1, err0, sd1, sd0;
    logic [15:0] c1 [25];
    logic [15:0] c0 [25];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_coeff_ctrl #(.COEFF_W(16), .NTAPS(25), .SYNC_TO_VS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(rdata1), .cfg_commit(cfg_commit), .cfg_busy(busy1), .cfg_err(err1),
        .cfg_err_clr(cfg_err_clr), .vs_i(vs_i), .swap_done(sd1),
        .coeff00(c1[0]),  .coeff01(c1[1]),  .coeff02(c1[2]),  .coeff03(c1[3]),  .coeff04(c1[4]),
        .coeff10(c1[5]),  .coeff11(c1[6]),  .coeff12(c1[7]),  .coeff13(c1[8]),  .coeff14(c1[9]),
        .coeff20(c1[10]), .coeff21(c1[11]), .coeff22(c1[12]), .coeff23(c1[13]), .coeff24(c1[14]),
        .coeff30(c1[15]), .coeff31(c1[16]), .coeff32(c1[17]), .coeff33(c1[18]), .coeff34(c1[19]),
        .coeff40(c1[20]), .coeff41(c1[21]), .coeff42(c1[22]), .coeff43(c1[23]), .coeff44(c1[24])
    );

    fir_coeff_ctrl #(.COEFF_W(16), .NTAPS(25), .SYNC_TO_VS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(rdata0), .cfg_commit(cfg_commit), .cfg_busy(busy0), .cfg_err(err0),
        .cfg_err_clr(cfg_err_clr), .vs_i(vs_i), .swap_done(sd0),
        .coeff00(c0[0]),  .coeff01(c0[1]),  .coeff02(c0[2]),  .coeff03(c0[3]),  .coeff04(c0[4]),
        .coeff10(c0[5]),  .coeff11(c0[6]),  .coeff12(c0[7]),  .coeff13(c0[8]),  .coeff14(c0[9]),
        .coeff20(c0[10]), .coeff21(c0[11]), .coeff22(c0[12]), .coeff23(c0[13]), .coeff24(c0[14]),
        .coeff30(c0[15]), .coeff31(c0[16]), .coeff32(c0[17]), .coeff33(c0[18]), .coeff34(c0[19]),
        .coeff40(c0[20]), .coeff41(c0[21]), .coeff42(c0[22]), .coeff43(c0[23]), .coeff44(c0[24])
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic        clr;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single-cycle register-interface behaviour, starting from the reset banks.
        vecs[0]  = '{1'b1, 5'd0,  16'h1111, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  16'h0000, 1'b0, 16'h1111, 1'b0};
        vecs[2]  = '{1'b1, 5'd12, 16'h2222, 1'b0, 16'h0100, 1'b0};
        vecs[3]  = '{1'b0, 5'd12, 16'h0000, 1'b0, 16'h2222, 1'b0};
        vecs[4]  = '{1'b1, 5'd25, 16'h1234, 1'b0, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 5'd25, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 5'd24, 16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 5'd31, 16'h5555, 1'b1, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 5'd0,  16'h0000, 1'b1, 16'h1111, 1'b0};
        vecs[9]  = '{1'b1, 5'd24, 16'h8001, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 5'd24, 16'h0000, 1'b0, 16'h8001, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_coeff22", c1[12], 16'h0100);
        chk("reset_coeff00", c1[0], 16'h0000);
        chk("reset_busy", busy1, 1'b0);
        chk("reset_err", err1, 1'b0);
        chk("reset_swap_done", sd1, 1'b0);
        chk("reset_rdata", rdata1, 16'h0000);

        for (int i = 0; i < 11; i++) begin
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr;
            cfg_wdata = vecs[i].wdata; cfg_err_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_rdata", i), rdata1, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), err1, vecs[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy1, 1'b0);
        end
        cfg_we = 1'b0; cfg_err_clr = 1'b0;
        chk("table_coeff00_untouched", c1[0], 16'h0000);
        chk("table_coeff22_untouched", c1[12], 16'h0100);

        // Full kernel load and frame-synced swap.
        for (int a = 0; a < 25; a++) begin
            cfg_we = 1'b1; cfg_addr = 5'(a);
            cfg_wdata = (a == 12) ? 16'h1800 : 16'hFF00;
            tick();
        end
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("A_busy_after_commit", busy1, 1'b1);
        chk("A_busy0_after_commit", busy0, 1'b1);
        tick();
        chk("A_sync0_swap_done", sd0, 1'b1);
        chk("A_sync0_coeff22", c0[12], 16'h1800);
        chk("A_wait_coeff22", c1[12], 16'h0100);
        chk("A_wait_swap_done", sd1, 1'b0);
        tick();
        chk("A_wait2_coeff00", c1[0], 16'h0000);
        chk("A_sync0_idle", busy0, 1'b0);
        vs_i = 1'b1;
        tick();
        chk("A_swap_done", sd1, 1'b1);
        chk("A_swap_busy", busy1, 1'b1);
        chk("A_coeff22", c1[12], 16'h1800);
        for (int a = 0; a < 25; a++)
            if (a != 12) chk($sformatf("A_tap%0d", a), c1[a], 16'hFF00);
        tick();
        chk("A_swap_done_one_cycle", sd1, 1'b0);
        chk("A_busy_falls", busy1, 1'b0);
        vs_i = 1'b0;
        tick();

        // Writes while a commit is pending are rejected and flagged.
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 16'h0077;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("B_busy", busy1, 1'b1);
        cfg_we = 1'b1; cfg_wdata = 16'h0042;
        tick();
        cfg_we = 1'b0;
        chk("B_err_set", err1, 1'b1);
        chk("B_rdata_old", rdata1, 16'h0077);
        tick();
        chk("B_shadow_unchanged", rdata1, 16'h0077);
        vs_i = 1'b1;
        tick();
        chk("B_swap_done", sd1, 1'b1);
        chk("B_coeff03", c1[3], 16'h0077);
        vs_i = 1'b0;
        tick();
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        chk("B_err_cleared", err1, 1'b0);

        // Commit on the same edge as a frame start waits for the next frame.
        cfg_we = 1'b1; cfg_addr = 5'd12; cfg_wdata = 16'h0300;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1; vs_i = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("C_busy", busy1, 1'b1);
        chk("C_no_swap", sd1, 1'b0);
        chk("C_coeff22_held", c1[12], 16'h1800);
        tick();
        chk("C_no_swap_vs_high", sd1, 1'b0);
        vs_i = 1'b0;
        tick();
        chk("C_still_busy", busy1, 1'b1);
        vs_i = 1'b1;
        tick();
        chk("C_swap_done", sd1, 1'b1);
        chk("C_coeff22", c1[12], 16'h0300);
        vs_i = 1'b0;
        tick();
        chk("C_idle", busy1, 1'b0);

        // Reset while pending drops the staged kernel.
        cfg_we = 1'b1; cfg_addr = 5'd12; cfg_wdata = 16'h1800;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("D_busy", busy1, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("D_async_coeff22", c1[12], 16'h0100);
        chk("D_async_coeff03", c1[3], 16'h0000);
        chk("D_async_busy", busy1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        vs_i = 1'b1;
        tick();
        chk("D_no_swap", sd1, 1'b0);
        chk("D_coeff22", c1[12], 16'h0100);
        chk("D_rdata_shadow_reset", rdata1, 16'h0100);
        vs_i = 1'b0;
        tick();
        vs_i = 1'b1;
        tick();
        chk("D_no_swap2", sd1, 1'b0);
        chk("D_busy_idle", busy1, 1'b0);
        vs_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
